// File: rtl/tx_link_sequencer_pkg.sv
// Shared constants and types for the transmit link sequencer.
// K-symbols are the 8b/10b control codes driven on every lane in lockstep.
package tx_link_sequencer_pkg;

  localparam int MAX_LINKS            = 4;
  localparam int ENCODER_DATA_IN_SIZE = 8;

  localparam logic [7:0] K28_5_IDLE = 8'hBC;
  localparam logic [7:0] K23_7_CC   = 8'hF7;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } tx_seq_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tx_link_sequencer_cc_scheduler.sv
// Clock-compensation schedule: free-running modulo-CC_PERIOD counter while run is high.
// The last CC_LEN counts of each period form the CC window.
module tx_link_sequencer_cc_scheduler #(
  parameter int CC_PERIOD = 5000,
  parameter int CC_LEN    = 4,
  parameter int CNT_W     = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic data_window,
  output logic cc_window
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CC_PERIOD - 1);
  localparam logic [CNT_W-1:0] CC_START = CNT_W'(CC_PERIOD - CC_LEN);

  logic [CNT_W-1:0] cc_cnt_q;
  logic [CNT_W-1:0] cc_cnt_d;

  always_comb begin
    cc_cnt_d = '0;
    if (run) begin
      cc_cnt_d = (cc_cnt_q == CNT_LAST) ? '0 : cc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc_cnt_q <= '0;
    end else begin
      cc_cnt_q <= cc_cnt_d;
    end
  end

  assign cc_window   = (cc_cnt_q >= CC_START);
  assign data_window = !cc_window;

endmodule

// File: rtl/tx_link_sequencer.sv
// Lockstep transmit controller feeding the multi-lane 8b/10b encoder: comma alignment
// burst, then user data (valid/ready) pre-empted by periodic CC bursts, idle commas as fill.
module tx_link_sequencer
  import tx_link_sequencer_pkg::*;
#(
  parameter int LANES        = MAX_LINKS,
  parameter int SYM_W        = ENCODER_DATA_IN_SIZE,
  parameter int ALIGN_CYCLES = 64,
  parameter int CC_PERIOD    = 5000,
  parameter int CC_LEN       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   link_en,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic [LANES-1:0]       tx_ctrl,
  input  logic [LANES*SYM_W-1:0] tx_data,
  output logic [LANES-1:0]       ctrl_out,
  output logic [LANES*SYM_W-1:0] data_out,
  output logic                   link_up,
  output logic                   cc_active
);

  localparam int CNT_MAX = max2(ALIGN_CYCLES, CC_PERIOD);
  localparam int CNT_W   = (CNT_MAX <= 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] ALIGN_LAST = CNT_W'(ALIGN_CYCLES - 1);
  localparam logic [SYM_W-1:0] IDLE_SYM   = SYM_W'(K28_5_IDLE);
  localparam logic [SYM_W-1:0] CC_SYM     = SYM_W'(K23_7_CC);

  tx_seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]       align_cnt_q, align_cnt_d;
  logic [LANES-1:0]       ctrl_q, ctrl_d;
  logic [LANES*SYM_W-1:0] data_q, data_d;
  logic                   link_up_q, link_up_d;
  logic                   cc_active_q, cc_active_d;
  logic                   data_window, cc_window;

  // Counter advances only in RUN with the link enabled; anything else clears it.
  tx_link_sequencer_cc_scheduler #(
    .CC_PERIOD (CC_PERIOD),
    .CC_LEN    (CC_LEN),
    .CNT_W     (CNT_W)
  ) u_cc_scheduler (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (link_en && (state_q == RUN)),
    .data_window (data_window),
    .cc_window   (cc_window)
  );

  // Valid/ready: tx_ready depends only on registered state and link_en, never on
  // tx_valid; a word transfers on a rising edge where both are high.
  assign tx_ready = link_en && (state_q == RUN) && data_window;

  always_comb begin
    state_d     = state_q;
    align_cnt_d = align_cnt_q;
    ctrl_d      = '1;
    data_d      = {LANES{IDLE_SYM}};
    cc_active_d = 1'b0;
    if (!link_en) begin
      state_d     = OFF;
      align_cnt_d = '0;
    end else begin
      case (state_q)
        OFF: begin
          state_d     = ALIGN;
          align_cnt_d = '0;
        end
        ALIGN: begin
          if (align_cnt_q == ALIGN_LAST) begin
            state_d     = RUN;
            align_cnt_d = '0;
          end else begin
            align_cnt_d = align_cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (cc_window) begin
            data_d      = {LANES{CC_SYM}};
            cc_active_d = 1'b1;
          end else if (tx_valid && tx_ready) begin
            ctrl_d = tx_ctrl;
            data_d = tx_data;
          end
        end
        default: begin
          state_d     = OFF;
          align_cnt_d = '0;
        end
      endcase
    end
    link_up_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= OFF;
      align_cnt_q <= '0;
      ctrl_q      <= '1;
      data_q      <= {LANES{IDLE_SYM}};
      link_up_q   <= 1'b0;
      cc_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      align_cnt_q <= align_cnt_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
      link_up_q   <= link_up_d;
      cc_active_q <= cc_active_d;
    end
  end

  assign ctrl_out  = ctrl_q;
  assign data_out  = data_q;
  assign link_up   = link_up_q;
  assign cc_active = cc_active_q;

endmodule

// File: tb/tb_tx_link_sequencer.sv
// Directed bench for tx_link_sequencer with a one-cycle-latency output scoreboard.
module tb_tx_link_sequencer;

  localparam int LANES        = 4;
  localparam int SYM_W        = 8;
  localparam int ALIGN_CYCLES = 8;
  localparam int CC_PERIOD    = 16;
  localparam int CC_LEN       = 4;
  localparam int W            = 1 + LANES + LANES * SYM_W;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   link_en = 1'b0;
  logic                   tx_valid = 1'b0;
  logic                   tx_ready;
  logic [LANES-1:0]       tx_ctrl = '0;
  logic [LANES*SYM_W-1:0] tx_data = '0;
  logic [LANES-1:0]       ctrl_out;
  logic [LANES*SYM_W-1:0] data_out;
  logic                   link_up;
  logic                   cc_active;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int rc;
  int seq;
  int low_cnt;
  bit took;

  tx_link_sequencer #(
    .LANES        (LANES),
    .SYM_W        (SYM_W),
    .ALIGN_CYCLES (ALIGN_CYCLES),
    .CC_PERIOD    (CC_PERIOD),
    .CC_LEN       (CC_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .link_en   (link_en),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_ctrl   (tx_ctrl),
    .tx_data   (tx_data),
    .ctrl_out  (ctrl_out),
    .data_out  (data_out),
    .link_up   (link_up),
    .cc_active (cc_active)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] pack(input logic cc, input logic [LANES-1:0] c,
                                        input logic [LANES*SYM_W-1:0] d);
    return {cc, c, d};
  endfunction

  function automatic logic [W-1:0] idle_word();
    return pack(1'b0, '1, {LANES{8'hBC}});
  endfunction

  function automatic logic [W-1:0] cc_word();
    return pack(1'b1, '1, {LANES{8'hF7}});
  endfunction

  // Lane i of word s: 0x11 * (1..15), so word 0 is 11,22,33,44 on lanes 0..3.
  function automatic logic [LANES*SYM_W-1:0] pattern(input int s);
    logic [LANES*SYM_W-1:0] d;
    d = '0;
    for (int i = 0; i < LANES; i++) begin
      d[i*SYM_W +: SYM_W] = 8'((8'h11) * (((s * LANES + i) % 15) + 1));
    end
    return d;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_out(input string tag);
    logic [W-1:0] e;
    check({tag, "_sb_depth"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, 64'({cc_active, ctrl_out, data_out}), 64'(e));
    end
  endtask

  // From OFF with link_en=1: one OFF cycle then exactly ALIGN_CYCLES of commas.
  task automatic bringup();
    for (int i = 0; i <= ALIGN_CYCLES; i++) begin
      check("align_ready", 64'(tx_ready), 64'd0);
      exp_q.push_back(idle_word());
      tick();
      compare_out("align_out");
      check("align_link_up", 64'(link_up), 64'(i == ALIGN_CYCLES));
    end
    rc = 0;
  endtask

  // One RUN cycle; rc is the CC-schedule position the bench expects this cycle.
  task automatic run_cycle(input bit valid, input logic [LANES-1:0] c,
                           input logic [LANES*SYM_W-1:0] d, output bit accepted);
    bit exp_ready;
    exp_ready = (rc % CC_PERIOD) < (CC_PERIOD - CC_LEN);
    tx_valid = valid;
    tx_ctrl  = c;
    tx_data  = d;
    check("tx_ready", 64'(tx_ready), 64'(exp_ready));
    accepted = valid && exp_ready;
    if (!exp_ready)   exp_q.push_back(cc_word());
    else if (valid)   exp_q.push_back(pack(1'b0, c, d));
    else              exp_q.push_back(idle_word());
    tick();
    compare_out("run_out");
    check("run_link_up", 64'(link_up), 64'd1);
    rc++;
  endtask

  initial begin
    // Reset held with link_en high
    rst_n   = 1'b0;
    link_en = 1'b1;
    repeat (3) tick();
    check("rst_ctrl", 64'(ctrl_out), 64'({LANES{1'b1}}));
    check("rst_data", 64'(data_out), 64'({LANES{8'hBC}}));
    check("rst_link_up", 64'(link_up), 64'd0);
    check("rst_tx_ready", 64'(tx_ready), 64'd0);
    check("rst_cc_active", 64'(cc_active), 64'd0);

    // Bring-up timing
    rst_n = 1'b1;
    bringup();

    // Data pass-through, ctrl=0
    seq = 0;
    for (int s = 0; s < 4; s++) begin
      run_cycle(1'b1, '0, pattern(seq), took);
      if (took) seq++;
    end
    check("pass_accepted", 64'(seq), 64'd4);

    // Idle fill
    for (int s = 0; s < 3; s++) begin
      run_cycle(1'b0, '0, pattern(seq), took);
    end

    // Continuous valid through a CC burst, stopping at the second CC output cycle
    low_cnt = 0;
    while (rc != 30) begin
      if (rc < CC_PERIOD && !tx_ready) low_cnt++;
      run_cycle(1'b1, LANES'(seq), pattern(seq), took);
      if (took) seq++;
    end
    check("cc_ready_low_cycles", 64'(low_cnt), 64'(CC_LEN));
    check("cc_before_drop", 64'(cc_active), 64'd1);

    // Drop link_en during the second cycle of a CC burst
    link_en = 1'b0;
    check("drop_tx_ready", 64'(tx_ready), 64'd0);
    exp_q.push_back(idle_word());
    tick();
    compare_out("drop_out");
    check("drop_link_up", 64'(link_up), 64'd0);

    // Re-enable: full alignment burst again, then data resumes
    tx_valid = 1'b0;
    link_en  = 1'b1;
    bringup();
    for (int s = 0; s < 3; s++) begin
      run_cycle(1'b1, '0, pattern(seq), took);
      if (took) seq++;
    end
    tx_valid = 1'b0;
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
